// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the memory access unit.
//   - 3-bit operation encodings (loads, stores)
//   - FSM state type and state constants
//   - MAU_MEM_BYTES: size of the addressable data memory in bytes
//   - small op-classification helpers used by RTL
package mau_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_SB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam int unsigned MAU_MEM_BYTES = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_RMW_RD = 3'd2;
  localparam state_t ST_WRITE  = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// mau_lane_merge: combinational lane logic for the memory access unit.
// Memory words are big-endian: lane 0 is bits 31:24, lane 3 is bits 7:0.
// Ports:
//   i_op          operation (mau_pkg OP_* encoding)
//   i_lane        byte lane within the word (addr[1:0])
//   i_load_word   word read from memory, source for load extraction
//   i_base_word   word captured during read-modify-write
//   i_wdata       right-justified store data
//   o_load_data   extracted and sign/zero-extended load result
//   o_store_word  word to write back (lane(s) replaced, or full word for SW)
module mau_lane_merge
  import mau_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_base_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (i_lane)
      2'd0: begin w_byte = i_load_word[31:24]; w_half = i_load_word[31:16]; end
      2'd1: begin w_byte = i_load_word[23:16]; w_half = i_load_word[23:8];  end
      2'd2: begin w_byte = i_load_word[15:8];  w_half = i_load_word[15:0];  end
      // A halfword at lane 3 would straddle words; it never reaches here.
      default: begin w_byte = i_load_word[7:0]; w_half = 16'h0000; end
    endcase
  end

  always_comb begin
    o_load_data = 32'h0;
    case (i_op)
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'h0, w_byte};
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'h0, w_half};
      OP_LW:   o_load_data = i_load_word;
      default: o_load_data = 32'h0;
    endcase
  end

  always_comb begin
    o_store_word = i_base_word;
    case (i_op)
      OP_SB: begin
        case (i_lane)
          2'd0:    o_store_word[31:24] = i_wdata[7:0];
          2'd1:    o_store_word[23:16] = i_wdata[7:0];
          2'd2:    o_store_word[15:8]  = i_wdata[7:0];
          default: o_store_word[7:0]   = i_wdata[7:0];
        endcase
      end
      OP_SH: begin
        if (i_lane[1]) o_store_word[15:0]  = i_wdata[15:0];
        else           o_store_word[31:16] = i_wdata[15:0];
      end
      OP_SW:   o_store_word = i_wdata;
      default: o_store_word = i_base_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit between a pipeline and a
// big-endian word-organised data memory (combinational read, negedge write).
// Sub-byte stores use read-modify-write.
//
// Handshake: a request is accepted on a posedge where req_valid && req_ready;
// req_ready is high only in IDLE, so req_valid is ignored while busy and in
// the RESP cycle. rsp_valid is a one-cycle pulse with no backpressure;
// rsp_rdata/rsp_err hold their value until the next response.
//
// Configuration macro: MAU_ERR_CHECK_EN
//   defined   : misaligned or out-of-range (addr >= 32) requests return
//               rsp_err=1 with no memory access.
//   undefined : rsp_err is always 0 and the address is forced legal
//               (addr[31:5] dropped, alignment bits cleared).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op/req_addr/req_wdata  operation, byte address, store data
//   rsp_valid/rsp_rdata/rsp_err response
//   MemAddr/MemWriteData/MemWrite/MemReadData  data memory port
//   o_dbg_state                current FSM state
module mem_access_unit
  import mau_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  input  logic [31:0] MemReadData,
  output state_t      o_dbg_state
);

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_addr_eff;
  logic [31:0] w_word_base;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;
  logic        w_mem_active;

  assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef MAU_ERR_CHECK_EN
  always_comb begin
    w_addr_eff = req_addr;
    w_err = (req_addr >= 32'(MAU_MEM_BYTES)) ||
            (is_half(req_op) && req_addr[0]) ||
            (is_word(req_op) && (req_addr[1:0] != 2'b00));
  end
`else
  // Upper address bits are deliberately discarded in this build.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^req_addr[31:5];

  always_comb begin
    w_addr_eff = {27'h0, req_addr[4:0]};
    if (is_half(req_op)) w_addr_eff[0]   = 1'b0;
    if (is_word(req_op)) w_addr_eff[1:0] = 2'b00;
    w_err = 1'b0;
  end
`endif

  assign w_word_base = {r_addr[31:2], 2'b00};

  mau_lane_merge u_lane_merge (
    .i_op         (r_op),
    .i_lane       (r_addr[1:0]),
    .i_load_word  (MemReadData),
    .i_base_word  (r_word),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'd0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_word      <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= req_op;
            r_addr  <= w_addr_eff;
            r_wdata <= req_wdata;
            if (w_err) begin
              // Response registers update on entry to RESP only.
              r_rsp_rdata <= 32'h0;
              r_rsp_err   <= 1'b1;
              r_state     <= ST_RESP;
            end else if (!is_store(req_op)) begin
              r_state <= ST_LOAD;
            end else if (req_op == OP_SW) begin
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_err   <= 1'b0;
          r_state     <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_word  <= MemReadData;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          r_state     <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_mem_active = (r_state == ST_LOAD) || (r_state == ST_RMW_RD) ||
                        (r_state == ST_WRITE);

  assign req_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign MemAddr      = w_mem_active ? w_word_base : 32'h0;
  assign MemWrite     = (r_state == ST_WRITE);
  assign MemWriteData = (r_state == ST_WRITE) ? w_store_word : 32'h0;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with a
// byte-array big-endian data memory. Works with or without MAU_ERR_CHECK_EN.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int EW = 37; // {lat[3:0], err, rdata[31:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic [31:0] MemReadData;
  state_t      dbg_state;

  logic [7:0]  mem     [0:31];
  logic [7:0]  ref_mem [0:31];
  logic [EW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int acc_count = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData),
    .o_dbg_state  (dbg_state)
  );

  // Data memory: combinational big-endian read, commit on negedge.
  logic [4:0] w_a;
  assign w_a = {MemAddr[4:2], 2'b00};
  assign MemReadData = {mem[w_a], mem[w_a | 5'd1], mem[w_a | 5'd2], mem[w_a | 5'd3]};

  always @(negedge clk) begin
    if (MemWrite === 1'b1) begin
      mem[w_a]        = MemWriteData[31:24];
      mem[w_a | 5'd1] = MemWriteData[23:16];
      mem[w_a | 5'd2] = MemWriteData[15:8];
      mem[w_a | 5'd3] = MemWriteData[7:0];
      wr_count++;
      last_wr_addr = MemAddr;
      last_wr_data = MemWriteData;
    end
    if (req_valid === 1'b1 && req_ready === 1'b1) acc_count++;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1 with the unit idle; returns at posedge+#1 after accept.
  task automatic send_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts cycles from accept to rsp_valid, bounded.
  task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 15) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [EW-1:0] got);
    int lat; logic [31:0] rd; logic er;
    send_req(op, addr, wdata);
    wait_rsp(lat, rd, er);
    got = {lat[3:0], er, rd};
    @(posedge clk); #1; // RESP -> IDLE
  endtask

  function automatic logic [EW-1:0] pack_exp(input int lat, input logic err, input logic [31:0] rd);
    logic [3:0] l;
    l = lat[3:0];
    return {l, err, rd};
  endfunction

  // Byte-level reference model; updates ref_mem for stores.
  task automatic model_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [EW-1:0] e);
    logic [4:0] a; logic err; logic hw, wd;
    logic [7:0] b; logic [15:0] h;
    hw = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    wd = (op == OP_LW) || (op == OP_SW);
    a = addr[4:0];
`ifdef MAU_ERR_CHECK_EN
    err = (addr >= 32) || (hw && addr[0]) || (wd && addr[1:0] != 2'b00);
`else
    err = 1'b0;
    if (hw) a[0] = 1'b0;
    if (wd) a[1:0] = 2'b00;
`endif
    b = ref_mem[a];
    h = {ref_mem[a], ref_mem[a + 5'd1]};
    if (err) e = pack_exp(1, 1'b1, 32'h0);
    else begin
      case (op)
        OP_LB:  e = pack_exp(2, 1'b0, {{24{b[7]}}, b});
        OP_LBU: e = pack_exp(2, 1'b0, {24'h0, b});
        OP_LH:  e = pack_exp(2, 1'b0, {{16{h[15]}}, h});
        OP_LHU: e = pack_exp(2, 1'b0, {16'h0, h});
        OP_LW:  e = pack_exp(2, 1'b0, {h, ref_mem[a + 5'd2], ref_mem[a + 5'd3]});
        OP_SB: begin ref_mem[a] = wdata[7:0]; e = pack_exp(3, 1'b0, 32'h0); end
        OP_SH: begin
          ref_mem[a] = wdata[15:8]; ref_mem[a + 5'd1] = wdata[7:0];
          e = pack_exp(3, 1'b0, 32'h0);
        end
        default: begin
          ref_mem[a] = wdata[31:24]; ref_mem[a + 5'd1] = wdata[23:16];
          ref_mem[a + 5'd2] = wdata[15:8]; ref_mem[a + 5'd3] = wdata[7:0];
          e = pack_exp(2, 1'b0, 32'h0);
        end
      endcase
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_err, MemWrite, MemAddr, MemWriteData} !== 99'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b we=%b addr=%h wdata=%h, expected all 0",
               rsp_valid, rsp_rdata, rsp_err, MemWrite, MemAddr, MemWriteData);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [2:0] ops [6] = '{OP_LB, OP_LHU, OP_LW, OP_LBU, OP_LH, OP_LB};
    logic [31:0] adr [6] = '{32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd3};
    logic [31:0] res [6] = '{32'hFFFFFF80, 32'h00003456, 32'h80123456,
                             32'h00000080, 32'hFFFF8012, 32'h00000056};
    logic [EW-1:0] got, e;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(pack_exp(2, 1'b0, res[i]));
      do_txn(ops[i], adr[i], 32'h0, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL load_%0d: got lat/err/rdata=%h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_sb_rmw();
    logic [EW-1:0] got, e;
    int wr0;
    wr0 = wr_count;
    exp_q.push_back(pack_exp(3, 1'b0, 32'h0));
    do_txn(OP_SB, 32'd6, 32'hFFFFFFAB, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++; $display("FAIL sb_rsp: got %h expected %h", got, e);
    end
    n_cmp++;
    if ({wr_count - wr0, last_wr_addr, last_wr_data} !== {1, 32'd4, 32'h1122AB44}) begin
      n_err++;
      $display("FAIL sb_write: got writes=%0d addr=%h data=%h expected 1/00000004/1122ab44",
               wr_count - wr0, last_wr_addr, last_wr_data);
    end
    exp_q.push_back(pack_exp(3, 1'b0, 32'h0));
    do_txn(OP_SH, 32'd4, 32'h00005566, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || last_wr_data !== 32'h5566AB44) begin
      n_err++; $display("FAIL sh_rmw: got %h wdata=%h expected %h wdata=5566ab44", got, last_wr_data, e);
    end
  endtask

  task automatic test_errors();
    logic [2:0] ops [3] = '{OP_LW, OP_SW, OP_LH};
`ifdef MAU_ERR_CHECK_EN
    logic [31:0] adr [3] = '{32'd2, 32'd40, 32'd1};
    logic [EW-1:0] res [3] = '{pack_exp(1, 1'b1, 32'h0), pack_exp(1, 1'b1, 32'h0),
                               pack_exp(1, 1'b1, 32'h0)};
`else
    // Forced legal: 2->0, 60->28, 37->4.
    logic [31:0] adr [3] = '{32'd2, 32'd60, 32'd37};
    logic [EW-1:0] res [3] = '{pack_exp(2, 1'b0, 32'h80123456), pack_exp(2, 1'b0, 32'h0),
                               pack_exp(2, 1'b0, 32'h00005566)};
`endif
    logic [EW-1:0] got, e;
    int wr0;
    for (int i = 0; i < 3; i++) begin
      wr0 = wr_count;
      exp_q.push_back(res[i]);
      do_txn(ops[i], adr[i], 32'hCAFEF00D, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL err_case_%0d: got %h expected %h", i, got, e);
      end
`ifdef MAU_ERR_CHECK_EN
      n_cmp++;
      if (wr_count != wr0) begin
        n_err++; $display("FAIL err_nowrite_%0d: got %0d writes expected 0", i, wr_count - wr0);
      end
`endif
    end
`ifndef MAU_ERR_CHECK_EN
    n_cmp++;
    if ({mem[28], mem[29], mem[30], mem[31]} !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL forced_sw: got %h expected cafef00d",
                        {mem[28], mem[29], mem[30], mem[31]});
    end
`endif
  endtask

  task automatic test_reset_abort();
    int wr0;
    mem[8] = 8'hA1; mem[9] = 8'hB2; mem[10] = 8'hC3; mem[11] = 8'hD4;
    wr0 = wr_count;
    send_req(OP_SH, 32'd8, 32'h0000BEEF);
    n_cmp++;
    if (dbg_state !== ST_RMW_RD) begin
      n_err++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_RMW_RD);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_err, MemWrite, MemAddr, MemWriteData} !== 99'h0) begin
      n_err++;
      $display("FAIL abort_outputs: got valid=%b rdata=%h err=%b we=%b addr=%h wdata=%h, expected all 0",
               rsp_valid, rsp_rdata, rsp_err, MemWrite, MemAddr, MemWriteData);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || wr_count != wr0 ||
        {mem[8], mem[9], mem[10], mem[11]} !== 32'hA1B2C3D4) begin
      n_err++;
      $display("FAIL abort_nowrite: got ready=%b writes=%0d mem=%h expected 1/0/a1b2c3d4",
               req_ready, wr_count - wr0, {mem[8], mem[9], mem[10], mem[11]});
    end
  endtask

  task automatic test_back_to_back();
    int lat, acc0; logic [31:0] rd; logic er;
    logic [EW-1:0] e;
    acc0 = acc_count;
    exp_q.push_back(pack_exp(2, 1'b0, 32'h0));
    exp_q.push_back(pack_exp(2, 1'b0, 32'hDEADBEEF));
    req_op = OP_SW; req_addr = 32'd12; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = OP_LW; req_wdata = 32'h0; // req_valid stays high while busy
    wait_rsp(lat, rd, er);
    e = exp_q.pop_front();
    n_cmp++;
    if ({lat[3:0], er, rd} !== e) begin
      n_err++; $display("FAIL b2b_sw: got %h expected %h", {lat[3:0], er, rd}, e);
    end
    @(posedge clk); #1; // IDLE, request pending
    @(posedge clk); #1; // accepted
    req_valid = 1'b0;
    wait_rsp(lat, rd, er);
    e = exp_q.pop_front();
    n_cmp++;
    if ({lat[3:0], er, rd} !== e) begin
      n_err++; $display("FAIL b2b_lw: got %h expected %h", {lat[3:0], er, rd}, e);
    end
    n_cmp++;
    if (acc_count - acc0 != 2) begin
      n_err++; $display("FAIL b2b_accepts: got %0d expected 2", acc_count - acc0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rsp_hold: got valid=%b rdata=%h expected 0/deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] addr, wd;
    logic [EW-1:0] got, e;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
`ifdef MAU_ERR_CHECK_EN
      addr = $urandom_range(0, 39);
`else
      addr = $urandom_range(0, 255);
`endif
      wd = $urandom;
      model_txn(op, addr, wd, e);
      exp_q.push_back(e);
      do_txn(op, addr, wd, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL rand_%0d op=%0d addr=%0d: got %h expected %h", i, op, addr, got, e);
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (mem[i] !== ref_mem[i]) begin
        n_err++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h80; mem[1] = 8'h12; mem[2] = 8'h34; mem[3] = 8'h56;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    test_reset();
    test_loads();
    test_sb_rmw();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL queue_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have the following ports, one clock and one synchronous active-low reset:
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  synchronous reset, active-low, sampled on posedge clk.
REQ-004 req_valid  input  1  pipeline requests a memory operation.
REQ-005 req_ready  output  1  unit idle; request accepted when req_valid && req_ready.
REQ-006 req_op  input  3  LB, LBU, LH, LHU, LW, SB, SH or SW.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-justified.
REQ-009 rsp_valid  output  1  one-cycle pulse: operation complete.
REQ-010 rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-011 rsp_err  output  1  valid with rsp_valid: misaligned or out-of-range request.
REQ-012 MemAddr  output  32  word-aligned address to data memory.
REQ-013 MemWriteData  output  32  write word to data memory.
REQ-014 MemWrite  output  1  memory write enable; memory commits on the negedge of the same cycle.
REQ-015 MemReadData  input  32  combinational read word; byte at MemAddr is bits 31:24 (big-endian).

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, RMW_RD, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 On accept, the unit SHALL register op, addr and wdata, and SHALL set word base W = addr & ~3 and lane L = addr[1:0].
REQ-018 Transitions SHALL be: loads IDLE->LOAD->RESP; SW IDLE->WRITE->RESP; SB/SH IDLE->RMW_RD->WRITE->RESP; error IDLE->RESP; RESP->IDLE.
REQ-019 MemAddr SHALL be W in LOAD, RMW_RD and WRITE, and 0 otherwise.
REQ-020 MemWrite SHALL be 1 only in WRITE.
REQ-021 In LOAD, the unit SHALL capture MemReadData at posedge and extract the lane: LB/LBU byte = word[31-8L -: 8]; LH/LHU half = word[31-8L -: 16].
REQ-022 LB and LH SHALL sign-extend; LBU, LHU and LW SHALL zero-extend or pass through.
REQ-023 In RMW_RD, the unit SHALL capture MemReadData; in WRITE, it SHALL drive the captured word with only the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
REQ-024 For SW, WRITE SHALL drive req_wdata unchanged.
REQ-025 rsp_valid SHALL be 1 only in RESP. rsp_rdata and rsp_err SHALL hold from RESP until the next RESP.
REQ-026 Latency, accept to rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-027 Error conditions SHALL be: halfword with addr[0]=1; word with addr[1:0]!=0; addr >= 32. On error the unit SHALL perform no memory access (MemWrite stays 0) and SHALL return rsp_rdata=0.
REQ-028 While the unit is busy, req_valid SHALL be ignored, and no request SHALL be accepted in the RESP cycle.
REQ-029 Back-to-back requests SHALL be supported: a request accepted in the IDLE cycle following RESP is valid.

Reset
REQ-030 While rst_n=0 at posedge: state SHALL go to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, MemWrite=0, MemAddr=0, MemWriteData=0, all captured registers 0.
REQ-031 A reset asserted in any state, including RMW_RD before WRITE, SHALL abort the operation with no partial write; after deassertion, req_ready=1 on the next cycle.

Configuration
REQ-032 The macro MAU_ERR_CHECK_EN SHALL select error checking.
REQ-033 With MAU_ERR_CHECK_EN defined, REQ-027 checking SHALL be active.
REQ-034 Without MAU_ERR_CHECK_EN, rsp_err SHALL be tied to 0 and the address SHALL be forced legal: addr[31:5] ignored, halfword addr[0] forced 0, word addr[1:0] forced 0.

Structure
REQ-035 Package mau_pkg SHALL hold the op encodings (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8-equivalent 3-bit: SB=3, SH=6, SW=7), the FSM state typedef, and MAU_MEM_BYTES=32.
REQ-036 A combinational sub-module mau_lane_merge SHALL perform lane extraction/extension and store merging, and SHALL be instantiated once.

Verification
REQ-037 Preload mem[0..3]=80 12 34 56; LB addr 0 -> rsp_rdata=FFFFFF80 at cycle +2, rsp_err=0.
REQ-038 Same memory; LHU addr 2 -> 00003456; LW addr 0 -> 80123456.
REQ-039 mem[4..7]=11 22 33 44; SB addr 6 wdata AB -> exactly one MemWrite cycle, MemAddr=4, MemWriteData=1122AB44; rsp at cycle +3.
REQ-040 With MAU_ERR_CHECK_EN: LW addr 2 -> rsp_err=1 at cycle +1, MemWrite never 1; SW addr 40 -> rsp_err=1.
REQ-041 SH addr 8 accepted, rst_n=0 while in RMW_RD -> mem[8..11] unchanged, all outputs 0, req_ready=1 one cycle after release.
REQ-042 Back-to-back SW addr 12 data DEADBEEF then LW addr 12 -> 2nd rsp_rdata=DEADBEEF; req_valid held during busy causes no extra accept.
